// File: rtl/fft_twiddle_gen.sv
// Twiddle-factor sequencer for a radix-2 DIT FFT: walks stage/butterfly counters, addresses two
// external sine LUTs and registers W = cos - j*sin behind a valid/ready output stage.
module fft_twiddle_gen #(
  parameter int unsigned LOG2N   = 8,
  parameter int unsigned DW      = 16,
  parameter bit          INVERSE = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [LOG2N-1:0]           lut_idx_re_o,
  output logic [LOG2N-1:0]           lut_idx_im_o,
  input  logic [DW-1:0]              lut_re_i,
  input  logic [DW-1:0]              lut_im_i,
  output logic                       tw_valid_o,
  input  logic                       tw_ready_i,
  output logic [DW-1:0]              tw_re_o,
  output logic [DW-1:0]              tw_im_o,
  output logic [$clog2(LOG2N)-1:0]   tw_stage_o,
  output logic [LOG2N-2:0]           tw_bfly_o,
  output logic                       tw_last_o
);

  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned BW = LOG2N - 1;

  localparam logic [SW-1:0]    LastStage = SW'(LOG2N - 1);
  localparam logic [BW-1:0]    LastBfly  = '1;
  localparam logic [LOG2N-1:0] QuarterN  = {2'b01, {(LOG2N - 2){1'b0}}};
  localparam logic [LOG2N-1:0] HalfN     = {1'b1, {(LOG2N - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [BW-1:0]   bfly_q, bfly_d;
  logic            done_q, done_d;

  logic            tw_valid_q;
  logic            tw_last_q;
  logic [DW-1:0]   tw_re_q, tw_im_q;
  logic [SW-1:0]   tw_stage_q;
  logic [BW-1:0]   tw_bfly_q;

  logic            ld;
  logic            accept;
  logic            at_final;
  logic [LOG2N-1:0] bfly_mask;
  logic [LOG2N-1:0] expo;
  logic [SW-1:0]   shamt;

  // Exponent keeps the low 'stage' bits of the butterfly index, scaled up to the N-point circle.
  always_comb begin
    bfly_mask = ~({LOG2N{1'b1}} << stage_q);
    shamt     = LastStage - stage_q;
    expo      = ({1'b0, bfly_q} & bfly_mask) << shamt;
  end

  // cos(x) = sin(x + N/4); -sin(x) = sin(x + N/2). Both wrap naturally in LOG2N bits.
  assign lut_idx_re_o = expo + QuarterN;
  assign lut_idx_im_o = INVERSE ? expo : (expo + HalfN);

  assign at_final = (stage_q == LastStage) && (bfly_q == LastBfly);
  assign ld       = (state_q == StRun) && (!tw_valid_q || tw_ready_i);
  assign accept   = tw_valid_q && tw_ready_i;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (start_i && !done_q) begin
          state_d = StRun;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      StRun: begin
        if (ld && at_final) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (accept) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ld) begin
      bfly_d = bfly_q + 1'b1;
      if (bfly_q == LastBfly) begin
        stage_d = at_final ? '0 : stage_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      stage_q <= '0;
      bfly_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      done_q  <= done_d;
    end
  end

  // Output stage: a load may coincide with an accept, in which case valid simply stays high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tw_valid_q <= 1'b0;
      tw_last_q  <= 1'b0;
      tw_re_q    <= '0;
      tw_im_q    <= '0;
      tw_stage_q <= '0;
      tw_bfly_q  <= '0;
    end else if (ld) begin
      tw_valid_q <= 1'b1;
      tw_last_q  <= at_final;
      tw_re_q    <= lut_re_i;
      tw_im_q    <= lut_im_i;
      tw_stage_q <= stage_q;
      tw_bfly_q  <= bfly_q;
    end else if (accept) begin
      tw_valid_q <= 1'b0;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign tw_valid_o = tw_valid_q;
  assign tw_last_o  = tw_last_q;
  assign tw_re_o    = tw_re_q;
  assign tw_im_o    = tw_im_q;
  assign tw_stage_o = tw_stage_q;
  assign tw_bfly_o  = tw_bfly_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Bench for fft_twiddle_gen: table of hand-computed twiddles plus sweeps with stalls and resets.
`timescale 1ns/1ps
module tb_fft_twiddle_gen;

  logic clk, rst_n, start, tw_ready;
  logic busy, done, tw_valid, tw_last;
  logic [7:0] lut_idx_re, lut_idx_im;
  logic signed [15:0] lut_re, lut_im, tw_re, tw_im;
  logic [2:0] tw_stage;
  logic [6:0] tw_bfly;

  logic inv_busy, inv_done, inv_valid, inv_last;
  logic [7:0] inv_idx_re, inv_idx_im;
  logic signed [15:0] inv_lut_re, inv_lut_im, inv_re, inv_im;
  logic [2:0] inv_stage;
  logic [6:0] inv_bfly;

  logic signed [15:0] sin_tab [256];

  int checks, errors;
  int cyc;

  fft_twiddle_gen #(.LOG2N(8), .DW(16), .INVERSE(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .lut_idx_re_o(lut_idx_re), .lut_idx_im_o(lut_idx_im), .lut_re_i(lut_re), .lut_im_i(lut_im),
    .tw_valid_o(tw_valid), .tw_ready_i(tw_ready), .tw_re_o(tw_re), .tw_im_o(tw_im),
    .tw_stage_o(tw_stage), .tw_bfly_o(tw_bfly), .tw_last_o(tw_last)
  );

  fft_twiddle_gen #(.LOG2N(8), .DW(16), .INVERSE(1'b1)) dut_inv (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(inv_busy), .done_o(inv_done),
    .lut_idx_re_o(inv_idx_re), .lut_idx_im_o(inv_idx_im), .lut_re_i(inv_lut_re),
    .lut_im_i(inv_lut_im), .tw_valid_o(inv_valid), .tw_ready_i(tw_ready), .tw_re_o(inv_re),
    .tw_im_o(inv_im), .tw_stage_o(inv_stage), .tw_bfly_o(inv_bfly), .tw_last_o(inv_last)
  );

  assign lut_re     = sin_tab[lut_idx_re];
  assign lut_im     = sin_tab[lut_idx_im];
  assign inv_lut_re = sin_tab[inv_idx_re];
  assign inv_lut_im = sin_tab[inv_idx_im];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sine LUT model: truncated quarter wave mirrored over the full period.
  initial begin
    int q [65];
    for (int i = 0; i < 65; i++) begin
      if (i == 64) q[i] = 32767;
      else q[i] = $rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));
    end
    for (int i = 0; i < 256; i++) begin
      if (i < 64)       sin_tab[i] = 16'(q[i]);
      else if (i < 128) sin_tab[i] = 16'(q[128 - i]);
      else if (i < 192) sin_tab[i] = 16'(-q[i - 128]);
      else              sin_tab[i] = 16'(-q[256 - i]);
    end
  end

  // Capture of accepted words, done pulses and stall stability.
  logic cap_en;
  int n_acc, n_done, hold_err, done_cyc, last_acc_cyc;
  int acc_key [1024];
  int acc_re [1024], acc_im [1024], acc_inv_im [1024], acc_idx_re [1024], acc_idx_im [1024];
  bit acc_last [1024];
  logic prev_v, prev_r, prev_last;
  logic signed [15:0] prev_re, prev_im;
  logic [2:0] prev_stage;
  logic [6:0] prev_bfly;
  logic [7:0] prev_idx_re, prev_idx_im;

  always @(negedge clk) begin
    if (cap_en) begin
      if (prev_v && !prev_r &&
          (tw_valid !== prev_v || tw_re !== prev_re || tw_im !== prev_im ||
           tw_stage !== prev_stage || tw_bfly !== prev_bfly || tw_last !== prev_last))
        hold_err++;
      if (tw_valid && tw_ready) begin
        if (n_acc < 1024) begin
          acc_key[n_acc]    = int'(tw_stage) * 128 + int'(tw_bfly);
          acc_re[n_acc]     = int'(tw_re);
          acc_im[n_acc]     = int'(tw_im);
          acc_inv_im[n_acc] = int'(inv_im);
          acc_last[n_acc]   = tw_last;
          acc_idx_re[n_acc] = int'(prev_idx_re);
          acc_idx_im[n_acc] = int'(prev_idx_im);
        end
        if (tw_stage == 3'd7 && tw_bfly == 7'd127) last_acc_cyc = cyc;
        n_acc++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    prev_v = tw_valid; prev_r = tw_ready; prev_re = tw_re; prev_im = tw_im;
    prev_stage = tw_stage; prev_bfly = tw_bfly; prev_last = tw_last;
    prev_idx_re = lut_idx_re; prev_idx_im = lut_idx_im;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_capture();
    cap_en = 1'b0; n_acc = 0; n_done = 0; hold_err = 0; done_cyc = -1; last_acc_cyc = -100;
  endtask

  task automatic run_until_done(input int bound, input bit rand_rdy, input int start_at,
                                output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (i == start_at);
      if (rand_rdy) tw_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
  endtask

  // Checks a captured sweep against the twiddle definition, in stage-major order.
  task automatic check_sweep(input string tag);
    int seq_err, val_err, last_err, e;
    seq_err = 0; val_err = 0; last_err = 0;
    chk({tag, "_count"}, n_acc, 1024);
    for (int k = 0; k < 1024; k++) begin
      e = ((k % 128) % (1 << (k / 128))) * (1 << (7 - k / 128));
      if (acc_key[k] != k) seq_err++;
      if (acc_re[k] != int'(sin_tab[(e + 64) % 256]) ||
          acc_im[k] != int'(sin_tab[(e + 128) % 256]) ||
          acc_inv_im[k] != int'(sin_tab[e])) val_err++;
      if (acc_last[k] != (k == 1023)) last_err++;
    end
    chk({tag, "_order_errs"}, seq_err, 0);
    chk({tag, "_value_errs"}, val_err, 0);
    chk({tag, "_last_errs"}, last_err, 0);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_done_timing"}, done_cyc, last_acc_cyc + 1);
  endtask

  typedef struct {
    int stage; int bfly; int idx_re; int idx_im; int re; int im;
  } vec_t;
  vec_t vecs [10];

  initial begin
    bit seen;
    int k;
    vecs[0] = '{0,   0,  64, 128,  32767,      0};
    vecs[1] = '{0, 127,  64, 128,  32767,      0};
    vecs[2] = '{7,   1,  65, 129,  32757,   -804};
    vecs[3] = '{7,  64, 128, 192,      0, -32767};
    vecs[4] = '{1,   1, 128, 192,      0, -32767};
    vecs[5] = '{2,   3, 160, 224, -23169, -23169};
    vecs[6] = '{3,   5, 144, 208, -12539, -30272};
    vecs[7] = '{7, 127, 191, 255, -32757,   -804};
    vecs[8] = '{6,   0,  64, 128,  32767,      0};
    vecs[9] = '{4,   8, 128, 192,      0, -32767};

    checks = 0; errors = 0; cyc = 0;
    clear_capture();
    rst_n = 1'b0; start = 1'b0; tw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(tw_valid), 0);
    chk("rst_last", int'(tw_last), 0);
    chk("rst_re", int'(tw_re), 0);
    chk("rst_im", int'(tw_im), 0);
    chk("rst_stage", int'(tw_stage), 0);
    chk("rst_bfly", int'(tw_bfly), 0);
    rst_n = 1'b1;

    // Sweep 1: ready held high; start pulse in cycle c, first word in c+2.
    @(posedge clk); #1;
    cap_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_busy_c1", int'(busy), 1);
    chk("lat_valid_c1", int'(tw_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid_c2", int'(tw_valid), 1);
    run_until_done(3000, 1'b0, 100, seen);
    chk("sweep1_done_seen", int'(seen), 1);
    start = 1'b1;  // in the done cycle: must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single", int'(done), 0);
    chk("start_in_done_ignored", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_sweep", int'(busy), 0);
    cap_en = 1'b0;
    check_sweep("sweep1");

    for (int v = 0; v < 10; v++) begin
      k = vecs[v].stage * 128 + vecs[v].bfly;
      chk($sformatf("vec%0d_s%0d_b%0d_idx_re", v, vecs[v].stage, vecs[v].bfly),
          acc_idx_re[k], vecs[v].idx_re);
      chk($sformatf("vec%0d_s%0d_b%0d_idx_im", v, vecs[v].stage, vecs[v].bfly),
          acc_idx_im[k], vecs[v].idx_im);
      chk($sformatf("vec%0d_s%0d_b%0d_re", v, vecs[v].stage, vecs[v].bfly),
          acc_re[k], vecs[v].re);
      chk($sformatf("vec%0d_s%0d_b%0d_im", v, vecs[v].stage, vecs[v].bfly),
          acc_im[k], vecs[v].im);
    end
    chk("inv_s7_b1_im", acc_inv_im[7 * 128 + 1], 804);
    chk("inv_s7_b127_im", acc_inv_im[7 * 128 + 127], 804);
    chk("inv_s2_b3_im", acc_inv_im[2 * 128 + 3], 23169);

    // Sweep 2: random ready stalls.
    clear_capture();
    cap_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(6000, 1'b1, -1, seen);
    tw_ready = 1'b1;
    chk("sweep2_done_seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #1;
    cap_en = 1'b0;
    check_sweep("sweep2");
    chk("sweep2_hold_errs", hold_err, 0);

    // Sweep 3: asynchronous reset at stage 3, then restart from the beginning.
    clear_capture();
    cap_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (tw_valid && tw_stage == 3'd3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stage3_reached", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(tw_valid), 0);
    chk("arst_last", int'(tw_last), 0);
    chk("arst_re", int'(tw_re), 0);
    chk("arst_im", int'(tw_im), 0);
    chk("arst_stage", int'(tw_stage), 0);
    chk("arst_bfly", int'(tw_bfly), 0);
    chk("arst_inv_valid", int'(inv_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_valid_c1", int'(tw_valid), 0);
    @(posedge clk); #1;
    chk("restart_valid_c2", int'(tw_valid), 1);
    chk("restart_stage", int'(tw_stage), 0);
    chk("restart_bfly", int'(tw_bfly), 0);
    chk("restart_re", int'(tw_re), 32767);
    chk("restart_im", int'(tw_im), 0);
    cap_en = 1'b0;
    chk("no_done_on_abort", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
